// File: rtl/bank_reader.sv
// Four-bank byte reader: a debounced-by-synchronizer manual read per rd_req press,
// plus optional automatic bank rotation when built with BANK_READER_SCAN_EN.
module bank_reader #(
  parameter int unsigned SCAN_DIV = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] bank_a,
  input  logic [7:0] bank_b,
  input  logic [7:0] bank_c,
  input  logic [7:0] bank_d,
  input  logic [1:0] rd_sel,
  input  logic       rd_req,
  input  logic       scan_mode,
  output logic [7:0] rd_data,
  output logic [1:0] rd_bank,
  output logic       rd_valid,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, CAPTURE, PRESENT, HOLD} state_t;

  state_t     state, state_next;
  logic       sync1, sync2, sync3;
  logic       rise;
  logic [1:0] sel_q;
  logic       scan_step;
  logic [1:0] scan_next;

  function automatic logic [7:0] pick(input logic [1:0] idx, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] c,
                                      input logic [7:0] d);
    case (idx)
      2'd0:    pick = a;
      2'd1:    pick = b;
      2'd2:    pick = c;
      default: pick = d;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= rd_req;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rise) state_next = CAPTURE;
      CAPTURE: state_next = PRESENT;
      PRESENT: state_next = HOLD;
      HOLD:    if (!sync2) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef BANK_READER_SCAN_EN
  localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] div;
  logic [1:0]       scan_idx;
  logic             scan_active;
  logic             terminal;

  // A same-cycle manual rise wins: the scan step is dropped and the divider parks at 0.
  assign scan_active = scan_mode && (state == IDLE) && !rise;
  assign terminal    = (div == DIV_W'(SCAN_DIV - 1));
  assign scan_step   = scan_active && terminal;
  assign scan_next   = scan_idx + 2'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div      <= '0;
      scan_idx <= '0;
    end else if (!scan_active) begin
      div <= '0;
    end else if (terminal) begin
      div      <= '0;
      scan_idx <= scan_next;
    end else begin
      div <= div + 1'b1;
    end
  end
`else
  localparam int unsigned unused_scan_div = SCAN_DIV;
  logic unused_scan_mode;

  assign unused_scan_mode = scan_mode;
  assign scan_step        = 1'b0;
  assign scan_next        = 2'd0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q    <= '0;
      rd_data  <= '0;
      rd_bank  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (state == IDLE && rise) sel_q <= rd_sel;
      if (state == CAPTURE) begin
        rd_data  <= pick(sel_q, bank_a, bank_b, bank_c, bank_d);
        rd_bank  <= sel_q;
        rd_valid <= 1'b1;
      end else if (scan_step) begin
        rd_data  <= pick(scan_next, bank_a, bank_b, bank_c, bank_d);
        rd_bank  <= scan_next;
        rd_valid <= 1'b1;
      end
    end
  end

endmodule
